imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//   Instruction-memory responder serving the PC stream issued by the fetch/PC unit.
//   Accepts one PC request per cycle over a valid/ready handshake.
//   Reads a word-addressed instruction ROM/RAM over a fixed-latency read pipeline.
//   Returns the instruction word, tagged with its PC, in request order through a response FIFO.
//   Sits between the PC generator and the decode/immgen stage.
// PARAMETERS
//   MEM_WORDS   1024  instruction memory depth in 32-bit words (power of 2)
//   RD_LATENCY  2     cycles from request acceptance to entry into the response FIFO (1..4)
//   RSP_DEPTH   4     response FIFO entries; also the cap on outstanding requests (power of 2)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   req_valid  in   1   PC request valid
//   req_ready  out  1   responder can accept a request this cycle
//   req_pc     in   32  byte address of the instruction to fetch
//   rsp_valid  out  1   response available at FIFO head
//   rsp_ready  in   1   consumer takes the response this cycle
//   rsp_instr  out  32  fetched instruction word
//   rsp_pc     out  32  PC the response belongs to
//   rsp_err    out  1   request was misaligned or out of range
//   prog_we    in   1   program-load write enable (one word per cycle)
//   prog_addr  in   $clog2(MEM_WORDS)  program-load word address
//   prog_data  in   32  program-load data
// BEHAVIOUR
// Reset and memory
//   - Reset forces rsp_valid=0, rsp_instr=0, rsp_pc=0 and rsp_err=0.
//   - Reset clears the read pipeline, the FIFO and the credit count; req_ready=1 once reset deasserts.
//   - Memory contents survive reset.
//   - Reset asserted mid-operation drops every in-flight request and queued response.
//   - No response for a dropped request ever appears.
// Request handshake and credits
//   - Accept = req_valid & req_ready. The requester must hold req_pc stable while req_valid=1 and req_ready=0.
//   - credits = in-flight pipeline entries + FIFO occupancy, range 0..RSP_DEPTH.
//   - req_ready = (credits < RSP_DEPTH). It is a registered-state function only; it never depends on req_valid.
//   - credits changes by +accept and -pop. A simultaneous accept and pop leaves credits unchanged.
//   - When credits == RSP_DEPTH-1, a simultaneous accept and pop leaves req_ready=1.
// Read pipeline
//   - The accepted request enters the FIFO exactly RD_LATENCY cycles later.
//   - With an empty FIFO, rsp_valid rises RD_LATENCY cycles after the accept edge.
//   - Word index = req_pc[31:2].
//   - Error case: req_pc[1:0] != 0, or word index >= MEM_WORDS.
//     - rsp_err=1 and rsp_instr=32'h0000_0013 (NOP).
//     - The memory is not indexed, and the request still consumes a credit.
//   - Normal case: rsp_err=0 and rsp_instr = mem[index].
// Response FIFO
//   - rsp_* are driven from the FIFO head. Pop = rsp_valid & rsp_ready.
//   - rsp_instr, rsp_pc and rsp_err hold stable while rsp_valid=1 and rsp_ready=0.
//   - Response order always equals request order.
//   - FIFO pointers wrap modulo RSP_DEPTH. Overflow is impossible by construction of the credit count.
//   - Full: no push can arrive without a prior credit, because credits cover FIFO occupancy.
//   - Empty: rsp_valid=0, and rsp_* hold their last popped values.
// Program load
//   - prog_we writes mem[prog_addr] at the clock edge.
//   - A read launched in the same cycle as a write to the same address returns the OLD word.
//   - The new word is visible to reads launched from the next cycle on.
// Throughput
//   - With rsp_ready held at 1, sustains 1 request and 1 response per cycle.
// TESTING
//   1. Load mem[0..3]=0x00500093,0x00A00113,0x002081B3,0x00000013; req pc 0,4,8,C back-to-back with rsp_ready=1
//      -> 4 responses, in order, first at accept+RD_LATENCY, rsp_err=0.
//   2. Hold rsp_ready=0 and issue 6 requests -> req_ready drops after 4 accepts and rsp_valid stays high.
//      Then pulse rsp_ready once -> req_ready returns the next cycle. All 6 responses arrive in order.
//   3. req_pc=0x2 -> rsp_err=1, rsp_instr=0x00000013, rsp_pc=0x2.
//      req_pc=MEM_WORDS*4 -> rsp_err=1, same NOP.
//   4. prog_we to addr 5 with 0xDEADBEEF in the same cycle as a request for pc 0x14 (old word 0x11111111)
//      -> response 0x11111111. The next request for pc 0x14 returns 0xDEADBEEF.
//   5. Assert reset with 2 requests in flight and 2 queued -> all outputs 0 immediately, memory retained.
//      After reset deasserts, a fresh request for pc 0 returns mem[0] with no stale responses.
//   6. Random valid/ready stress of 1000 requests -> scoreboard shows order preserved, no loss, no duplicates.
//      credits never exceeds RSP_DEPTH.

Source files
------------

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response and program-load bus for imem_fetch_responder.
// master = PC generator / loader side, slave = responder.
interface imem_fetch_responder_if #(
  parameter int MEM_WORDS = 1024
);
  localparam int AW = $clog2(MEM_WORDS);

  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_pc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [31:0]   rsp_pc;
  logic          rsp_err;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;

  modport master (
    output req_valid, req_pc, rsp_ready,
    output prog_we, prog_addr, prog_data,
    input  req_ready, rsp_valid,
    input  rsp_instr, rsp_pc, rsp_err
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    input  prog_we, prog_addr, prog_data,
    output req_ready, rsp_valid,
    output rsp_instr, rsp_pc, rsp_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: credit-gated PC requests, fixed-latency
// ROM/RAM read pipeline, in-order response FIFO tagged with the PC.
module imem_fetch_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_fetch_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_mem [MEM_WORDS];

  logic          r_pv   [RD_LATENCY];
  logic [31:0]   r_pd   [RD_LATENCY];
  logic [31:0]   r_ppc  [RD_LATENCY];
  logic          r_perr [RD_LATENCY];

  logic [31:0]   r_fd   [RSP_DEPTH];
  logic [31:0]   r_fpc  [RSP_DEPTH];
  logic          r_ferr [RSP_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_cred;

  logic [31:0]   r_last_instr;
  logic [31:0]   r_last_pc;
  logic          r_last_err;

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_acc;
  logic          w_pop;
  logic          w_push;
  logic          w_valid;

  assign w_idx   = bus.req_pc[AW+1:2];
  assign w_err   = (bus.req_pc[1:0] != 2'b00)
                 | (|bus.req_pc[31:AW+2]);
  assign w_acc   = bus.req_valid & bus.req_ready;
  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid & bus.rsp_ready;
  assign w_push  = r_pv[RD_LATENCY-1];

  assign bus.req_ready = (r_cred < CW'(RSP_DEPTH));
  assign bus.rsp_valid = w_valid;
  assign bus.rsp_instr = w_valid ? r_fd[r_rp]   : r_last_instr;
  assign bus.rsp_pc    = w_valid ? r_fpc[r_rp]  : r_last_pc;
  assign bus.rsp_err   = w_valid ? r_ferr[r_rp] : r_last_err;

  // Program-load write port; contents are kept across reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we) r_mem[bus.prog_addr] <= bus.prog_data;
  end

  // Read pipeline: stage 0 samples memory (old word on same-cycle write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pv[i]   <= 1'b0;
        r_pd[i]   <= '0;
        r_ppc[i]  <= '0;
        r_perr[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_acc;
      if (w_acc) begin
        r_pd[0]   <= w_err ? NOP : r_mem[w_idx];
        r_ppc[0]  <= bus.req_pc;
        r_perr[0] <= w_err;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pd[i]   <= r_pd[i-1];
        r_ppc[i]  <= r_ppc[i-1];
        r_perr[i] <= r_perr[i-1];
      end
    end
  end

  // FIFO storage; never written when full since credits cover occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fd[r_wp]   <= r_pd[RD_LATENCY-1];
      r_fpc[r_wp]  <= r_ppc[RD_LATENCY-1];
      r_ferr[r_wp] <= r_perr[RD_LATENCY-1];
    end
  end

  // FIFO pointers, occupancy and outstanding-request credits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_cred <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_cred <= r_cred + CW'(w_acc) - CW'(w_pop);
    end
  end

  // Hold the last popped response so outputs stay put when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_instr <= '0;
      r_last_pc    <= '0;
      r_last_err   <= 1'b0;
    end else if (w_pop) begin
      r_last_instr <= r_fd[r_rp];
      r_last_pc    <= r_fpc[r_rp];
      r_last_err   <= r_ferr[r_rp];
    end
  end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder.
// Queue-based reference model plus per-cycle output comparison.
module tb_imem_fetch_responder;
  localparam int MW = 1024;
  localparam int L  = 2;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_responder_if #(.MEM_WORDS(MW)) bus ();

  imem_fetch_responder #(
    .MEM_WORDS (MW),
    .RD_LATENCY(L),
    .RSP_DEPTH (D)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    int          rdy;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mmem [MW];
  logic [31:0] l_instr, l_pc;
  logic        l_err;
  int cyc = 0, n_chk = 0, n_pass = 0, n_acc = 0, n_dpop = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e)
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    else
      n_pass++;
  endtask

  // Reference model: every accepted request is a queue entry that becomes
  // visible L edges after acceptance; the queue length is the credit count.
  always @(posedge clk) begin : model
    bit          v, r;
    ent_t        e;
    logic [31:0] pc;
    if (rst) begin
      q.delete();
      l_instr = '0; l_pc = '0; l_err = 1'b0;
    end else begin
      v = q.size() > 0 && q[0].rdy <= cyc;
      r = q.size() < D;
      if (v && bus.rsp_ready) begin
        l_instr = q[0].instr; l_pc = q[0].pc; l_err = q[0].err;
        void'(q.pop_front());
      end
      if (bus.req_valid && r) begin
        pc      = bus.req_pc;
        e.pc    = pc;
        e.err   = (pc[1:0] != 2'b00) || ((pc >> 2) >= MW);
        e.instr = e.err ? 32'h0000_0013 : mmem[pc[11:2]];
        e.rdy   = cyc + 1 + L;
        q.push_back(e);
        n_acc++;
      end
    end
    if (bus.prog_we) mmem[bus.prog_addr] = bus.prog_data;
    cyc++;
  end

  // Compare DUT outputs with the model every cycle out of reset.
  always @(negedge clk) begin : cmp
    bit v;
    if (!rst) begin
      v = q.size() > 0 && q[0].rdy <= cyc;
      chk("req_ready", bus.req_ready, q.size() < D);
      chk("rsp_valid", bus.rsp_valid, v);
      if (v) begin
        chk("rsp_instr", bus.rsp_instr, q[0].instr);
        chk("rsp_pc", bus.rsp_pc, q[0].pc);
        chk("rsp_err", bus.rsp_err, q[0].err);
      end else begin
        chk("hold_instr", bus.rsp_instr, l_instr);
        chk("hold_pc", bus.rsp_pc, l_pc);
        chk("hold_err", bus.rsp_err, l_err);
      end
      if (bus.rsp_valid && bus.rsp_ready) n_dpop++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = 10'(a); bus.prog_data = d;
    step();
    bus.prog_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_pc = pc;
    while (!bus.req_ready && n < 50) begin step(); n++; end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string nm, input logic [31:0] pc,
                            input logic [31:0] ins, input logic err);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 20) begin step(); n++; end
    chk({nm, "_valid"}, bus.rsp_valid, 1);
    chk({nm, "_pc"}, bus.rsp_pc, pc);
    chk({nm, "_instr"}, bus.rsp_instr, ins);
    chk({nm, "_err"}, bus.rsp_err, err);
    step();
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin step(); n++; end
    chk("drain_done", n < 200, 1);
  endtask

  function automatic logic [31:0] rnd_pc();
    int r = $urandom_range(0, 19);
    if (r == 0) return {20'h0, 10'($urandom_range(0, MW-1)), 2'($urandom_range(1, 3))};
    if (r == 1) return 32'($urandom_range(MW, 32'h3FFF_FFFF)) << 2;
    return 32'($urandom_range(0, MW-1)) << 2;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n, n0, p0;
    bit hold;
    bus.req_valid = 1'b0; bus.req_pc = '0; bus.rsp_ready = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    step(); step();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_instr", bus.rsp_instr, 0);
    chk("rst_rsp_pc", bus.rsp_pc, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1);

    for (int i = 0; i < MW; i++) load(i, $urandom);
    load(0, 32'h0050_0093); load(1, 32'h00A0_0113);
    load(2, 32'h0020_81B3); load(3, 32'h0000_0013);
    load(5, 32'h1111_1111);

    // 1: back-to-back fetch of pc 0,4,8,C
    bus.rsp_ready = 1'b1; bus.req_valid = 1'b1;
    bus.req_pc = 32'h0; step();
    bus.req_pc = 32'h4; step();
    bus.req_pc = 32'h8; step();
    chk("t1_first_valid", bus.rsp_valid, 1);
    chk("t1_first_instr", bus.rsp_instr, 32'h0050_0093);
    chk("t1_first_pc", bus.rsp_pc, 32'h0);
    bus.req_pc = 32'hC; step();
    chk("t1_second_instr", bus.rsp_instr, 32'h00A0_0113);
    bus.req_valid = 1'b0; step();
    chk("t1_third_instr", bus.rsp_instr, 32'h0020_81B3);
    step();
    chk("t1_fourth_pc", bus.rsp_pc, 32'hC);
    step();
    chk("t1_empty_valid", bus.rsp_valid, 0);
    chk("t1_empty_hold", bus.rsp_instr, 32'h0000_0013);

    // 2: credit back-pressure with rsp_ready low
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_pc = 32'h10 + 32'(4 * i); step();
    end
    chk("t2_ready_low", bus.req_ready, 0);
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_head_pc", bus.rsp_pc, 32'h10);
    bus.req_pc = 32'h20; step(); step();
    chk("t2_still_low", bus.req_ready, 0);
    bus.rsp_ready = 1'b1; step();
    bus.rsp_ready = 1'b0;
    chk("t2_ready_back", bus.req_ready, 1);
    step();
    chk("t2_full_again", bus.req_ready, 0);
    bus.req_pc = 32'h24; bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin step(); n++; end
    step();
    bus.req_valid = 1'b0;
    drain();

    // 3: misaligned, out-of-range and last valid word
    send(32'h2);
    expect_rsp("t3_misalign", 32'h2, 32'h0000_0013, 1'b1);
    send(32'(MW * 4));
    expect_rsp("t3_oor", 32'(MW * 4), 32'h0000_0013, 1'b1);
    send(32'(MW * 4 - 4));
    expect_rsp("t3_lastword", 32'(MW * 4 - 4), mmem[MW-1], 1'b0);

    // 4: write and read of the same word in one cycle
    bus.prog_we = 1'b1; bus.prog_addr = 10'd5;
    bus.prog_data = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1; bus.req_pc = 32'h14;
    step();
    bus.prog_we = 1'b0; bus.req_valid = 1'b0;
    expect_rsp("t4_old", 32'h14, 32'h1111_1111, 1'b0);
    send(32'h14);
    expect_rsp("t4_new", 32'h14, 32'hDEAD_BEEF, 1'b0);

    // 5: reset with 2 in flight and 2 queued
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_pc = 32'(4 * i); step();
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    q.delete(); l_instr = '0; l_pc = '0; l_err = 1'b0;
    #1;
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_rsp_instr", bus.rsp_instr, 0);
    chk("t5_rsp_pc", bus.rsp_pc, 0);
    chk("t5_rsp_err", bus.rsp_err, 0);
    step(); step();
    rst = 1'b0;
    chk("t5_req_ready", bus.req_ready, 1);
    step(); step(); step();
    chk("t5_no_stale", bus.rsp_valid, 0);
    send(32'h0);
    expect_rsp("t5_fresh", 32'h0, 32'h0050_0093, 1'b0);

    // 6: random stress
    n0 = n_acc; p0 = n_dpop; n = 0; hold = 1'b0;
    while (n_acc - n0 < 1000 && n < 20000) begin
      if (!hold) begin
        bus.req_valid = ($urandom_range(0, 9) < 7);
        bus.req_pc = rnd_pc();
      end
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      bus.prog_we   = ($urandom_range(0, 19) == 0);
      bus.prog_addr = 10'($urandom);
      bus.prog_data = $urandom;
      hold = bus.req_valid && !bus.req_ready;
      step(); n++;
    end
    bus.req_valid = 1'b0; bus.prog_we = 1'b0;
    chk("t6_accepts", n_acc - n0 >= 1000, 1);
    drain();
    step();
    chk("t6_pops_eq_accepts", n_dpop - p0, n_acc - n0);
    chk("t6_final_empty", bus.rsp_valid, 0);
    chk("t6_final_ready", bus.req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
